// File: rtl/tx_fsm_pkg.sv
// Shared types and constants for the serial transmit framer.
// The parity feature is compiled in with TX_PARITY_EN.
package tx_fsm_pkg;

   localparam int STATE_W   = 3;
   localparam int DATA_BITS = 8;
   localparam int SEL_W     = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/tx_serial_fsm_baud.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last clock.
// Held at zero while clear is high so each frame starts a fresh period.
module tx_baud_counter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_end
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear || bit_end) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/tx_serial_fsm.sv
// UART-style framer driving an 8-to-1 bit-select mux and the serial line.
// Define TX_PARITY_EN to insert an even-parity bit before stop.
module tx_serial_fsm
   import tx_fsm_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             mux_bit,
   output logic [SEL_W-1:0] bit_sel,
   output logic             tx,
   output logic             busy,
   output logic             done
);

   tx_state_e        state_q;
   logic             tx_q;
   logic [SEL_W-1:0] sel_q;
   logic [2:0]       idx_q;
   logic             bit_end;
`ifdef TX_PARITY_EN
   logic             par_q;
`endif

   tx_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q == IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         sel_q   <= '0;
         idx_q   <= '0;
`ifdef TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (start_valid && start_ready) begin
                  state_q <= START;
                  tx_q    <= 1'b0;
                  sel_q   <= '0;
                  idx_q   <= '0;
`ifdef TX_PARITY_EN
                  par_q   <= 1'b0;
`endif
               end
            end
            START: begin
               if (bit_end) begin
                  state_q <= DATA;
                  tx_q    <= mux_bit;
                  sel_q   <= sel_q + SEL_W'(1);
`ifdef TX_PARITY_EN
                  par_q   <= par_q ^ mux_bit;
`endif
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef TX_PARITY_EN
                     state_q <= PARITY;
                     tx_q    <= par_q;
`else
                     state_q <= STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     // sel_q wraps 7 -> 0 once bit 7 is on the line
                     tx_q  <= mux_bit;
                     sel_q <= sel_q + SEL_W'(1);
                     idx_q <= idx_q + 3'd1;
`ifdef TX_PARITY_EN
                     par_q <= par_q ^ mux_bit;
`endif
                  end
               end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

   assign tx          = tx_q;
   assign bit_sel     = sel_q;
   assign start_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == STOP) && bit_end;

endmodule

// File: doc/tx_serial_fsm.md
# tx_serial_fsm

Transmit framing state machine that sits directly upstream of the 8-to-1 bit-select mux. It accepts a start request for an 8-bit word held in the upstream data register and steps the mux's 3-bit select through bits 0..7. It registers each selected bit onto the serial line inside a UART-style frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. The data register drives the mux inputs A..H (A = bit 0); this block drives only the select and consumes the mux output.

## Interface
- CLKS_PER_BIT, default 16: clocks per serial bit period; legal range 2..65535.
- CNT_W, default 16: baud counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_valid  input  1  request to send the word currently on the mux inputs.
- start_ready  output  1  high only in IDLE; a frame is accepted when start_valid && start_ready.
- mux_bit  input  1  output of the 8-to-1 mux for the current bit_sel.
- bit_sel  output  3  mux select; index of the next data bit to load.
- tx  output  1  registered serial line; idles high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the last clock of the stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Reset values: state = IDLE, tx = 1, bit_sel = 0, baud count = 0, parity = 0, busy = 0, done = 0, start_ready = 1.
- IDLE: tx = 1. On handshake, go to START with tx <= 0, count <= 0, parity <= 0. start_valid without the handshake has no effect.
- Bit period: count runs 0..CLKS_PER_BIT-1. The period ends on the clock where count == CLKS_PER_BIT-1; count then wraps to 0.
- End of START period: tx <= mux_bit (bit 0), bit_sel <= 1, parity ^= mux_bit, go to DATA.
- End of data period k, for k = 0..6: tx <= mux_bit, bit_sel <= k+1, with bit_sel wrapping from 7 to 0 after bit 7 is loaded. parity ^= mux_bit.
- Data bit counter: a separate 3-bit index that leaves DATA at the end of data period 7.
  - With the macro: tx <= parity and go to PARITY.
  - Without the macro: tx <= 1 and go to STOP.
- End of PARITY period: tx <= 1, go to STOP.
- End of STOP period: done = 1 for that clock, go to IDLE. There is a minimum of one IDLE clock between frames.
- Mux input stability: upstream must hold the mux inputs stable while busy. This block only samples mux_bit on period-end clocks.
- Reset mid-frame: asynchronous return to all reset values. tx goes high immediately and no partial frame resumes.

## Timing
- Handshake at edge T0 → tx falls at T0.
- Each bit lasts exactly CLKS_PER_BIT clocks.
- Frame length: 10*CLKS_PER_BIT clocks without the macro, 11*CLKS_PER_BIT with it. The handshake clock is not included.
- done is asserted during the final clock of STOP. start_ready rises on the following clock.
- bit_sel always leads tx by one data bit. The mux path is combinational, so a mux_bit change settles within the same cycle.

## Configuration
- PARITY_EN_PARITY_EN is not used; the macro is TX_PARITY_EN.
- With TX_PARITY_EN defined: the PARITY state is present, and an even-parity bit (XOR of the 8 data bits) is sent between bit 7 and stop.
- Without it: the PARITY state, the parity register and the parity logic are absent, and frames are 10 bits long.

## Structure
- Shared package tx_fsm_pkg holds:
  - the state encoding constants (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4) and the 3-bit state width;
  - DATA_BITS = 8 and SEL_W = 3.
- One sub-module, tx_baud_counter (CLKS_PER_BIT, CNT_W):
  - inputs clk, rst_n and a clear;
  - output bit_end, high when count == CLKS_PER_BIT-1.

## Test plan
- Reset, then idle 20 clocks → tx = 1, start_ready = 1, bit_sel = 0, busy = 0 throughout.
- CLKS_PER_BIT = 4, word 0xA5, macro off → tx sequence per 4-clock period is 0, then 1 0 1 0 0 1 0 1, then 1; done pulses once at clock 40; bit_sel visits 1..7,0.
- Same bench with TX_PARITY_EN: word 0xA5 → parity bit 0; word 0x07 → parity bit 1; frame is 44 clocks.
- start_valid held high continuously while sending 0x3C, 0xC3 → two complete frames with exactly one idle-high clock between them; start_valid is ignored while busy.
- rst_n asserted asynchronously mid-DATA, at bit 4 → tx = 1 and bit_sel = 0 before the next edge; after release a new 0xFF frame is sent cleanly.
- CLKS_PER_BIT = 2 (minimum), word 0x01 → every bit is exactly 2 clocks and bit 0 is 1; no off-by-one at count wrap.
